// File: rtl/slot_mem_sequencer.sv
// Turns qualified CPU memory cycles from the slot mappers into single SDRAM req/ack
// or fixed-latency cart-SRAM transactions, stalling the CPU on reads and posting writes.
module slot_mem_sequencer #(
   parameter int ADDR_W   = 27,
   parameter int SRAM_AW  = 18,
   parameter int SRAM_LAT = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               mreq,
   input  logic               cpu_rd,
   input  logic               cpu_wr,
   input  logic [7:0]         cpu_dout,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_rnw,
   input  logic               ram_cs,
   input  logic               sram_cs,
   output logic               cpu_wait,
   output logic [7:0]         rd_data,
   output logic               rd_valid,
   output logic               timeout_err,
   output logic               sdram_req,
   input  logic               sdram_ack,
   output logic [ADDR_W-1:0]  sdram_addr,
   output logic               sdram_we,
   output logic [7:0]         sdram_din,
   input  logic [7:0]         sdram_dout,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we,
   output logic [7:0]         sram_din,
   input  logic [7:0]         sram_dout
);

   typedef enum logic [1:0] {IDLE, SD_REQ, SR_WAIT, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] LAT_LAST = 8'(SRAM_LAT - 1);

   state_t state, state_nx;

   logic act, act_q, start, start_ok, discard;
   logic launch, launch_pend, pend_set, ack_hit, tmo_hit, busy_rd;

   logic              pend_v, pend_rd, pend_sd;
   logic [ADDR_W-1:0] pend_addr;
   logic [7:0]        pend_data;

   logic              cur_rd, cur_sd;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        cur_data;

   logic [7:0] cnt, cap_q, rd_q, done_data;

   assign act      = mreq & (cpu_rd | cpu_wr) & (ram_cs | sram_cs);
   assign start    = act & ~act_q & ~reset;
   assign discard  = ~cpu_rd & mem_rnw;
   assign start_ok = start & ~discard;
   // An access that cannot launch this cycle is parked until the in-flight one drains.
   assign pend_set = start_ok & ((state != IDLE) | pend_v);

   always_comb begin
      state_nx    = state;
      launch      = 1'b0;
      launch_pend = 1'b0;
      ack_hit     = 1'b0;
      tmo_hit     = 1'b0;
      case (state)
         IDLE: begin
            if (pend_v) begin
               launch      = 1'b1;
               launch_pend = 1'b1;
               state_nx    = pend_sd ? SD_REQ : SR_WAIT;
            end else if (start_ok) begin
               launch   = 1'b1;
               state_nx = ram_cs ? SD_REQ : SR_WAIT;
            end
         end
         SD_REQ: begin
            if (sdram_ack) begin
               ack_hit  = 1'b1;
               state_nx = cur_rd ? DONE : IDLE;
            end else if (cnt == TMO_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = cur_rd ? DONE : IDLE;
            end
         end
         SR_WAIT: begin
            if (cnt == LAT_LAST) state_nx = cur_rd ? DONE : IDLE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Edge detector keeps tracking through reset so a held strobe cannot retrigger.
   always_ff @(posedge clk_sys) act_q <= act;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= IDLE;
         pend_v      <= 1'b0;
         pend_rd     <= 1'b0;
         pend_sd     <= 1'b0;
         pend_addr   <= '0;
         pend_data   <= '0;
         cur_rd      <= 1'b0;
         cur_sd      <= 1'b0;
         cur_addr    <= '0;
         cur_data    <= '0;
         cnt         <= '0;
         cap_q       <= '1;
         rd_q        <= '1;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (launch) begin
            cur_rd   <= launch_pend ? pend_rd   : cpu_rd;
            cur_sd   <= launch_pend ? pend_sd   : ram_cs;
            cur_addr <= launch_pend ? pend_addr : mem_addr;
            cur_data <= launch_pend ? pend_data : cpu_dout;
         end
         if (launch_pend) pend_v <= 1'b0;
         if (pend_set) begin
            pend_v    <= 1'b1;
            pend_rd   <= cpu_rd;
            pend_sd   <= ram_cs;
            pend_addr <= mem_addr;
            pend_data <= cpu_dout;
         end
         if (state_nx != state)
            cnt <= '0;
         else if (state == SD_REQ || state == SR_WAIT)
            cnt <= cnt + 8'd1;
         if (ack_hit)
            cap_q <= sdram_dout;
         else if (tmo_hit)
            cap_q <= '1;
         if (tmo_hit) timeout_err <= 1'b1;
         if (state == DONE) rd_q <= done_data;
      end
   end

   assign busy_rd    = cur_rd & (state == SD_REQ || state == SR_WAIT);
   assign cpu_wait   = ~reset & ((start_ok & (cpu_rd | (state != IDLE) | pend_v)) | pend_v | busy_rd);

   assign sdram_req  = (state == SD_REQ);
   assign sdram_we   = sdram_req & ~cur_rd;
   assign sdram_addr = cur_addr;
   assign sdram_din  = cur_data;
   assign sram_addr  = cur_addr[SRAM_AW-1:0];
   assign sram_din   = cur_data;
   assign sram_we    = (state == SR_WAIT) & (cnt == 8'd0) & ~cur_rd;

   assign done_data  = cur_sd ? cap_q : sram_dout;
   assign rd_valid   = (state == DONE);
   assign rd_data    = rd_valid ? done_data : rd_q;

endmodule

// File: tb/tb_slot_mem_sequencer.sv
// Directed bench for slot_mem_sequencer: vector table for single accesses plus
// hand-written sequences for posted-write ordering, SDRAM timeout and mid-transaction reset.
module tb_slot_mem_sequencer;

   logic        clk = 1'b0;
   logic        reset, mreq, cpu_rd, cpu_wr, mem_rnw, ram_cs, sram_cs, sdram_ack;
   logic [7:0]  cpu_dout, sdram_dout, sram_dout;
   logic [26:0] mem_addr;
   logic        cpu_wait, rd_valid, timeout_err, sdram_req, sdram_we, sram_we;
   logic [7:0]  rd_data, sdram_din, sram_din;
   logic [26:0] sdram_addr;
   logic [17:0] sram_addr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   slot_mem_sequencer #(.ADDR_W(27), .SRAM_AW(18), .SRAM_LAT(1), .TIMEOUT(255)) dut (
      .clk_sys(clk), .reset(reset), .mreq(mreq), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_dout(cpu_dout), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .ram_cs(ram_cs),
      .sram_cs(sram_cs), .cpu_wait(cpu_wait), .rd_data(rd_data), .rd_valid(rd_valid),
      .timeout_err(timeout_err), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
      .sdram_addr(sdram_addr), .sdram_we(sdram_we), .sdram_din(sdram_din),
      .sdram_dout(sdram_dout), .sram_addr(sram_addr), .sram_we(sram_we),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // One-cycle-latency BRAM behind the cart-SRAM port.
   logic [7:0] bram [0:1023];
   always @(posedge clk) begin
      if (sram_we) bram[sram_addr[9:0]] <= sram_din;
      sram_dout <= bram[sram_addr[9:0]];
   end

   // Logs the address of every new SDRAM request.
   int          req_cnt = 0;
   logic        req_d = 1'b0;
   logic [26:0] req_log [0:15];
   always @(negedge clk) begin
      if (sdram_req && !req_d && req_cnt < 16) req_log[req_cnt] = sdram_addr;
      if (sdram_req && !req_d) req_cnt = req_cnt + 1;
      req_d = sdram_req;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mreq = 0; cpu_rd = 0; cpu_wr = 0; mem_rnw = 0; ram_cs = 0; sram_cs = 0;
      sdram_ack = 0; cpu_dout = '0; sdram_dout = '0; mem_addr = '0;
   endtask

   typedef struct {
      logic mreq, rd, wr, ram, sram, rnw, ack;
      logic [26:0] addr;
      logic [7:0]  wdata, sdout;
      logic ewait, ereq, ewe, esrwe, evalid;
      logic [7:0]  edata;
   } vec_t;

   function automatic vec_t mk(input logic [6:0] ctl, input logic [26:0] a, input logic [7:0] wd,
                               input logic [7:0] sd, input logic [4:0] ex, input logic [7:0] ed);
      vec_t v;
      {v.mreq, v.rd, v.wr, v.ram, v.sram, v.rnw, v.ack} = ctl;
      v.addr = a; v.wdata = wd; v.sdout = sd;
      {v.ewait, v.ereq, v.ewe, v.esrwe, v.evalid} = ex;
      v.edata = ed;
      return v;
   endfunction

   vec_t vt [22];

   initial begin
      int          base, n, reqc;
      logic        got;

      // ctl = {mreq,rd,wr,ram,sram,rnw,ack}; ex = {wait,req,we,sram_we,rd_valid}
      // SDRAM read 0x0012345, ack three cycles after req, data A5
      vt[0]  = mk(7'b1101000, 27'h0012345, 8'h00, 8'h00, 5'b10000, 8'hFF);
      vt[1]  = mk(7'b1101000, 27'h0012345, 8'h00, 8'h00, 5'b11000, 8'hFF);
      vt[2]  = mk(7'b1101000, 27'h0012345, 8'h00, 8'h00, 5'b11000, 8'hFF);
      vt[3]  = mk(7'b1101000, 27'h0012345, 8'h00, 8'h00, 5'b11000, 8'hFF);
      vt[4]  = mk(7'b1101001, 27'h0012345, 8'h00, 8'hA5, 5'b11000, 8'hFF);
      vt[5]  = mk(7'b1101000, 27'h0012345, 8'h00, 8'h00, 5'b00001, 8'hA5);
      vt[6]  = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'hA5);
      // SRAM write 3C to 0x100, then read it back
      vt[7]  = mk(7'b1010100, 27'h0000100, 8'h3C, 8'h00, 5'b00000, 8'hA5);
      vt[8]  = mk(7'b0000000, 27'h0000100, 8'h00, 8'h00, 5'b00010, 8'hA5);
      vt[9]  = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'hA5);
      vt[10] = mk(7'b1100100, 27'h0000100, 8'h00, 8'h00, 5'b10000, 8'hA5);
      vt[11] = mk(7'b1100100, 27'h0000100, 8'h00, 8'h00, 5'b10000, 8'hA5);
      vt[12] = mk(7'b1100100, 27'h0000100, 8'h00, 8'h00, 5'b00001, 8'h3C);
      vt[13] = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'h3C);
      // writes into read-only regions are dropped
      vt[14] = mk(7'b1011010, 27'h0000200, 8'h77, 8'h00, 5'b00000, 8'h3C);
      vt[15] = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'h3C);
      vt[16] = mk(7'b1010110, 27'h0000300, 8'h77, 8'h00, 5'b00000, 8'h3C);
      vt[17] = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'h3C);
      // both chip selects: SDRAM wins, immediate ack
      vt[18] = mk(7'b1101100, 27'h0000055, 8'h00, 8'h00, 5'b10000, 8'h3C);
      vt[19] = mk(7'b1101101, 27'h0000055, 8'h00, 8'h5A, 5'b11000, 8'h3C);
      vt[20] = mk(7'b1101100, 27'h0000055, 8'h00, 8'h00, 5'b00001, 8'h5A);
      vt[21] = mk(7'b0000000, 27'h0000000, 8'h00, 8'h00, 5'b00000, 8'h5A);

      for (int i = 0; i < 1024; i++) bram[i] = 8'h00;
      idle_inputs();
      reset = 1;
      tick(); tick();
      reset = 0;
      #2;
      chk("rst.wait", cpu_wait, 0);
      chk("rst.req", sdram_req, 0);
      chk("rst.rd_data", rd_data, 8'hFF);
      chk("rst.rd_valid", rd_valid, 0);
      chk("rst.tmo", timeout_err, 0);
      chk("rst.sram_we", sram_we, 0);
      chk("rst.sdram_addr", sdram_addr, 0);

      base = req_cnt;
      foreach (vt[i]) begin
         tick();
         {mreq, cpu_rd, cpu_wr, ram_cs, sram_cs, mem_rnw, sdram_ack} =
            {vt[i].mreq, vt[i].rd, vt[i].wr, vt[i].ram, vt[i].sram, vt[i].rnw, vt[i].ack};
         mem_addr = vt[i].addr; cpu_dout = vt[i].wdata; sdram_dout = vt[i].sdout;
         #2;
         chk($sformatf("vec%0d.wait", i), cpu_wait, vt[i].ewait);
         chk($sformatf("vec%0d.req", i), sdram_req, vt[i].ereq);
         chk($sformatf("vec%0d.we", i), sdram_we, vt[i].ewe);
         chk($sformatf("vec%0d.sram_we", i), sram_we, vt[i].esrwe);
         chk($sformatf("vec%0d.rd_valid", i), rd_valid, vt[i].evalid);
         chk($sformatf("vec%0d.rd_data", i), rd_data, vt[i].edata);
         if (vt[i].ereq) chk($sformatf("vec%0d.addr", i), sdram_addr, vt[i].addr);
      end
      tick(); #2;
      chk("tbl.req_count", req_cnt - base, 2);

      // back-to-back posted SDRAM writes, first ack ten cycles after req
      base = req_cnt;
      tick(); idle_inputs(); mreq = 1; cpu_wr = 1; ram_cs = 1; mem_addr = 27'h00000A1; cpu_dout = 8'h11;
      #2; chk("b2b.w1_wait", cpu_wait, 0);
      tick(); mreq = 0; cpu_wr = 0; #2;
      chk("b2b.w1_req", sdram_req, 1);
      chk("b2b.w1_we", sdram_we, 1);
      chk("b2b.w1_din", sdram_din, 8'h11);
      tick(); mreq = 1; cpu_wr = 1; mem_addr = 27'h00000A2; cpu_dout = 8'h22;
      #2; chk("b2b.w2_wait", cpu_wait, 1);
      for (int i = 3; i <= 10; i++) begin
         tick(); #2;
         chk($sformatf("b2b.hold%0d", i), {cpu_wait, sdram_req, sdram_addr[7:0]}, {2'b11, 8'hA1});
      end
      tick(); sdram_ack = 1; #2; chk("b2b.ack1_addr", sdram_addr, 27'h00000A1);
      tick(); sdram_ack = 0; #2;
      chk("b2b.gap_req", sdram_req, 0);
      chk("b2b.gap_wait", cpu_wait, 1);
      tick(); #2;
      chk("b2b.w2_req", sdram_req, 1);
      chk("b2b.w2_addr", sdram_addr, 27'h00000A2);
      chk("b2b.w2_din", sdram_din, 8'h22);
      chk("b2b.w2_nowait", cpu_wait, 0);
      tick(); mreq = 0; cpu_wr = 0; #2;
      tick(); sdram_ack = 1; #2;
      tick(); sdram_ack = 0; #2;
      chk("b2b.end_req", sdram_req, 0);
      chk("b2b.req_count", req_cnt - base, 2);
      chk("b2b.order0", req_log[base], 27'h00000A1);
      chk("b2b.order1", req_log[base + 1], 27'h00000A2);

      // read with no ack: times out after 255 request cycles
      tick(); mreq = 1; cpu_rd = 1; ram_cs = 1; mem_addr = 27'h00ABCDE;
      #2; chk("tmo.start_wait", cpu_wait, 1);
      n = 0; reqc = 0; got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         tick(); #2;
         n++;
         if (sdram_req) reqc++;
         if (rd_valid) begin
            got = 1;
            chk("tmo.rd_data", rd_data, 8'hFF);
            chk("tmo.err", timeout_err, 1);
            chk("tmo.wait", cpu_wait, 0);
         end
      end
      chk("tmo.completed", got, 1);
      chk("tmo.latency", n, 256);
      chk("tmo.req_cycles", reqc, 255);
      tick(); idle_inputs(); #2;
      tick(); sdram_ack = 1; sdram_dout = 8'h99; #2;
      chk("tmo.stray_ack_valid", rd_valid, 0);
      tick(); sdram_ack = 0; #2;
      chk("tmo.stray_ack_req", sdram_req, 0);
      chk("tmo.stray_ack_data", rd_data, 8'hFF);
      chk("tmo.sticky", timeout_err, 1);

      // reset while a write is in SD_REQ and a second write is queued
      base = req_cnt;
      tick(); mreq = 1; cpu_wr = 1; ram_cs = 1; mem_addr = 27'h00000C1; cpu_dout = 8'h31; #2;
      tick(); mreq = 0; cpu_wr = 0; #2;
      chk("rmid.req", sdram_req, 1);
      tick(); mreq = 1; cpu_wr = 1; mem_addr = 27'h00000C2; cpu_dout = 8'h32; #2;
      chk("rmid.queued_wait", cpu_wait, 1);
      tick(); reset = 1; mreq = 0; cpu_wr = 0; #2;
      tick(); reset = 0; #2;
      chk("rmid.req_drop", sdram_req, 0);
      chk("rmid.wait", cpu_wait, 0);
      chk("rmid.tmo_clr", timeout_err, 0);
      chk("rmid.rd_data", rd_data, 8'hFF);
      for (int i = 0; i < 20; i++) begin
         tick(); #2;
      end
      chk("rmid.req_count", req_cnt - base, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
